// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port burst memory arbiter.
// State encodings, default geometry and one-hot grant values.
package mem_arb_pkg;

  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 8;
  localparam int BURST_LEN_DEF = 4;
  localparam int BEAT_W        = $clog2(BURST_LEN_DEF);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_BUSY  = 3'd2,
    S_WAIT_READY = 3'd3,
    S_XFER       = 3'd4,
    S_DONE       = 3'd5
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_P0   = 2'b01;
  localparam logic [1:0] GNT_P1   = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the port that did not
// own the bus last wins. Purely combinational.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = GNT_NONE;
    if (req == 2'b11) begin
      gnt = last ? GNT_P0 : GNT_P1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_arbiter_2p.sv
// Two-requester burst arbiter for a single 8-bit memory port.
// Optional macro ARB_TIMEOUT_EN adds err and a bounded memory wait.
module mem_arbiter_2p
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int TIMEOUT   = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic              p0_rd,
  input  logic              p0_wr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_beat,
  output logic              p0_done,
  output logic              p0_stall,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              p1_rd,
  input  logic              p1_wr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_beat,
  output logic              p1_done,
  output logic              p1_stall,
  output logic [1:0]        grant,
  output logic [ADDR_W-1:0] addr_mem,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [DATA_W-1:0] wdata_mem,
  input  logic [DATA_W-1:0] rdata_mem,
`ifdef ARB_TIMEOUT_EN
  output logic              err,
`endif
  input  logic              ready_mem
);

  localparam int BW = $clog2(BURST_LEN);
  localparam int HW = ADDR_W - BW;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              wr_op_q, wr_op_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [HW-1:0]     base_q, base_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [1:0]        rbeat_q, rbeat_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic [1:0]        req;
  logic [1:0]        arb_gnt;
  logic              xfer;
  logic              wbeat;
  logic              fin;
  logic              tmo;
  logic              unused_addr;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1) + 1;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic              wait_st;
`endif

  assign req = {p1_rd | p1_wr, p0_rd | p0_wr};

  rr_arbiter2 u_arb (
    .req  (req),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  // Write-back wins over fill on the same port; the fill re-arbitrates.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wr_op_d = wr_op_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    tmo     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|arb_gnt) begin
          grant_d = arb_gnt;
          wr_op_d = arb_gnt[1] ? p1_wr : p0_wr;
          rd_d    = ~wr_op_d;
          wr_d    = wr_op_d;
          base_d  = arb_gnt[1] ? p1_addr[ADDR_W-1:BW]
                               : p0_addr[ADDR_W-1:BW];
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!ready_mem) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        state_d = ready_mem ? S_XFER : S_WAIT_READY;
      end
      S_WAIT_READY: begin
        if (ready_mem) state_d = S_XFER;
      end
      S_XFER: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BW'(BURST_LEN - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        grant_d = GNT_NONE;
        last_d  = grant_q[1];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    wait_st = (state_q == S_ISSUE) || (state_q == S_WAIT_BUSY)
           || (state_q == S_WAIT_READY);
    tmo       = wait_st && (tmo_cnt_q == TW'(TIMEOUT));
    tmo_cnt_d = wait_st ? tmo_cnt_q + 1'b1 : '0;
    if (tmo) begin
      state_d   = S_IDLE;
      grant_d   = GNT_NONE;
      rd_d      = 1'b0;
      wr_d      = 1'b0;
      last_d    = grant_q[1];
      tmo_cnt_d = '0;
    end
`endif
  end

  // Read data is registered, so the read strobe trails by one cycle.
  always_comb begin
    xfer     = (state_q == S_XFER);
    wbeat    = xfer & wr_op_q;
    rbeat_d  = (xfer & ~wr_op_q) ? grant_q : GNT_NONE;
    rdata0_d = rbeat_d[0] ? rdata_mem : '0;
    rdata1_d = rbeat_d[1] ? rdata_mem : '0;
    fin      = (state_q == S_DONE) | tmo;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      grant_q  <= GNT_NONE;
      wr_op_q  <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      base_q   <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      rbeat_q  <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      wr_op_q  <= wr_op_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      rbeat_q  <= rbeat_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end

  assign err = tmo;
`endif

  assign grant     = grant_q;
  assign rd_mem    = rd_q;
  assign wr_mem    = wr_q;
  assign addr_mem  = {base_q, xfer ? cnt_q : {BW{1'b0}}};
  assign wdata_mem = wbeat ? (grant_q[1] ? p1_wdata : p0_wdata) : '0;
  assign p0_beat   = (wbeat & grant_q[0]) | rbeat_q[0];
  assign p1_beat   = (wbeat & grant_q[1]) | rbeat_q[1];
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign p0_done   = fin & grant_q[0];
  assign p1_done   = fin & grant_q[1];
  assign p0_stall  = req[0] & ~p0_done;
  assign p1_stall  = req[1] & ~p1_done;

  assign unused_addr = ^{p0_addr[BW-1:0], p1_addr[BW-1:0]};

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Directed bench for mem_arbiter_2p with a beat/done scoreboard.
// Build with ARB_TIMEOUT_EN to also cover the memory wait timeout.
module tb_mem_arbiter_2p;

  typedef struct {
    bit          port;
    bit          wr;
    logic [7:0]  data;
    logic [15:0] addr;
  } ent_t;

  logic        clock;
  logic        reset_n;
  logic [15:0] p0_addr, p1_addr;
  logic        p0_rd, p0_wr, p1_rd, p1_wr;
  logic [7:0]  p0_wdata, p1_wdata;
  logic [7:0]  p0_rdata, p1_rdata;
  logic        p0_beat, p0_done, p0_stall;
  logic        p1_beat, p1_done, p1_stall;
  logic [1:0]  grant;
  logic [15:0] addr_mem;
  logic        rd_mem, wr_mem;
  logic [7:0]  wdata_mem, rdata_mem;
  logic        ready_mem;
`ifdef ARB_TIMEOUT_EN
  logic        err;
`endif

  logic [7:0]  rdv [4];
  logic [7:0]  wdv [4];
  ent_t        sb[$];
  bit          dq[$];
  logic [15:0] prev_addr;
  int          lat_drop, lat_busy;
  bit          stuck;
  int          total, bad;

  assign rdata_mem = rdv[addr_mem[1:0]];
  assign p1_wdata  = wdv[addr_mem[1:0]];

  mem_arbiter_2p #(.TIMEOUT(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .p0_addr   (p0_addr),
    .p0_rd     (p0_rd),
    .p0_wr     (p0_wr),
    .p0_wdata  (p0_wdata),
    .p0_rdata  (p0_rdata),
    .p0_beat   (p0_beat),
    .p0_done   (p0_done),
    .p0_stall  (p0_stall),
    .p1_addr   (p1_addr),
    .p1_rd     (p1_rd),
    .p1_wr     (p1_wr),
    .p1_wdata  (p1_wdata),
    .p1_rdata  (p1_rdata),
    .p1_beat   (p1_beat),
    .p1_done   (p1_done),
    .p1_stall  (p1_stall),
    .grant     (grant),
    .addr_mem  (addr_mem),
    .rd_mem    (rd_mem),
    .wr_mem    (wr_mem),
    .wdata_mem (wdata_mem),
    .rdata_mem (rdata_mem),
`ifdef ARB_TIMEOUT_EN
    .err       (err),
`endif
    .ready_mem (ready_mem)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input bit port, input bit wr,
                            input logic [15:0] base);
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{port, wr, wr ? wdv[k] : rdv[k],
                     base | 16'(k)});
    end
    dq.push_back(port);
  endtask

  task automatic wait_done(input bit port);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if ((!port && p0_done) || (port && p1_done)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", {31'b0, ok}, 1);
  endtask

  // Memory model: a command is accepted after lat_drop cycles,
  // then the port stays busy for lat_busy cycles.
  initial begin
    ready_mem = 1'b1;
    forever begin
      @(negedge clock);
      if ((rd_mem || wr_mem) && ready_mem) begin
        repeat (lat_drop) @(posedge clock);
        #1 ready_mem = 1'b0;
        repeat (lat_busy) @(posedge clock);
        while (stuck) @(posedge clock);
        #1 ready_mem = 1'b1;
      end
    end
  end

  initial begin
    ent_t e;
    prev_addr = '0;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (p0_beat || p1_beat) begin
          chk("beat_excl", {31'b0, p0_beat & p1_beat}, 0);
          if (sb.size() == 0) begin
            chk("sb_empty", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            chk("beat_port", {31'b0, p1_beat}, {31'b0, e.port});
            if (e.wr) begin
              chk("wdata_mem", wdata_mem, e.data);
              chk("waddr", addr_mem, e.addr);
            end else begin
              chk("rdata", e.port ? p1_rdata : p0_rdata, e.data);
              chk("rdata_other", e.port ? p0_rdata : p1_rdata, 0);
              chk("raddr", prev_addr, e.addr);
            end
          end
        end
        if (p0_done || p1_done) begin
          chk("done_excl", {31'b0, p0_done & p1_done}, 0);
          if (dq.size() == 0) begin
            chk("dq_empty", dq.size(), 1);
          end else begin
            chk("done_port", {31'b0, p1_done}, {31'b0, dq.pop_front()});
          end
        end
      end
      prev_addr = addr_mem;
    end
  end

  initial begin
    total = 0;
    bad = 0;
    stuck = 1'b0;
    lat_drop = 2;
    lat_busy = 4;
    rdv[0] = 8'h11; rdv[1] = 8'h22; rdv[2] = 8'h33; rdv[3] = 8'h44;
    wdv[0] = 8'hAA; wdv[1] = 8'hBB; wdv[2] = 8'hCC; wdv[3] = 8'hDD;
    reset_n = 1'b0;
    p0_addr = '0; p0_rd = 0; p0_wr = 0; p0_wdata = 8'h5A;
    p1_addr = '0; p1_rd = 0; p1_wr = 0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_grant", grant, 0);
    chk("rst_rd", rd_mem, 0);
    chk("rst_wr", wr_mem, 0);
    chk("rst_addr", addr_mem, 0);
    chk("rst_wdata", wdata_mem, 0);
    chk("rst_rdata", p0_rdata, 0);
    chk("rst_strobes", {p0_beat, p0_done, p1_beat, p1_done}, 0);
    reset_n = 1'b1;

    // Single read on p0 with a slow memory
    @(negedge clock);
    push_burst(0, 0, 16'h0090);
    p0_addr = 16'h0093;
    p0_rd = 1'b1;
    @(negedge clock);
    chk("s1_grant", grant, 2'b01);
    chk("s1_rd", rd_mem, 1);
    chk("s1_addr", addr_mem, 16'h0090);
    chk("s1_stall", {p0_stall, p1_stall}, 2'b10);
    wait_done(0);
    chk("s1_stall_done", p0_stall, 0);
    p0_rd = 1'b0;

    // Both read from reset: p0, p1, p0, p1
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    lat_drop = 0;
    lat_busy = 1;
    push_burst(0, 0, 16'h1000);
    push_burst(1, 0, 16'h2000);
    push_burst(0, 0, 16'h1000);
    push_burst(1, 0, 16'h2000);
    p0_addr = 16'h1002; p0_rd = 1'b1;
    p1_addr = 16'h2003; p1_rd = 1'b1;
    @(negedge clock);
    chk("s2_first", grant, 2'b01);
    wait_done(0);
    @(negedge clock);
    chk("s2_gap", grant, 2'b00);
    @(negedge clock);
    chk("s2_second", grant, 2'b10);
    wait_done(1);
    wait_done(0);
    wait_done(1);
    p0_rd = 1'b0;
    p1_rd = 1'b0;

    // Same port write-back then fill
    @(negedge clock);
    push_burst(1, 1, 16'hC098);
    push_burst(1, 0, 16'hC098);
    p1_addr = 16'hC09B;
    p1_rd = 1'b1;
    p1_wr = 1'b1;
    @(negedge clock);
    chk("s3_wr", {rd_mem, wr_mem}, 2'b01);
    chk("s3_grant", grant, 2'b10);
    wait_done(1);
    p1_wr = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("s3_rd", {rd_mem, wr_mem}, 2'b10);
    chk("s3_raddr", addr_mem, 16'hC098);
    wait_done(1);
    p1_rd = 1'b0;

    // Reset in the middle of a read burst
    @(negedge clock);
    push_burst(0, 0, 16'h0040);
    p0_addr = 16'h0041;
    p0_rd = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (grant == 2'b01 && addr_mem[1:0] == 2'd2) break;
    end
    chk("s4_reached", addr_mem, 16'h0042);
    #2 reset_n = 1'b0;
    #1;
    chk("s4_grant", grant, 0);
    chk("s4_cmd", {rd_mem, wr_mem}, 0);
    chk("s4_addr", addr_mem, 0);
    chk("s4_strobes", {p0_beat, p0_done, p1_beat, p1_done}, 0);
    chk("s4_rdata", p0_rdata, 0);
    sb.delete();
    dq.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    push_burst(0, 0, 16'h0040);
    @(negedge clock);
    chk("s4_regrant", grant, 2'b01);
    chk("s4_reissue", rd_mem, 1);
    wait_done(0);
    p0_rd = 1'b0;

    // Memory stays ready after issue: command must be held
    lat_drop = 5;
    lat_busy = 2;
    @(negedge clock);
    push_burst(1, 0, 16'h0100);
    p1_addr = 16'h0101;
    p1_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("s5_hold", {rd_mem, p1_beat}, 2'b10);
    end
    wait_done(1);
    p1_rd = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // Memory never comes back
    begin
      int n;
      n = 0;
      stuck = 1'b1;
      lat_drop = 0;
      @(negedge clock);
      dq.push_back(0);
      p0_addr = 16'h0200;
      p0_rd = 1'b1;
      for (int i = 1; i < 40; i++) begin
        @(negedge clock);
        if (p0_done) begin
          n = i;
          break;
        end
      end
      chk("to_cycle", n, 9);
      chk("to_err", err, 1);
      p0_rd = 1'b0;
      @(negedge clock);
      chk("to_grant", grant, 0);
      chk("to_err_low", err, 0);
      stuck = 1'b0;
      repeat (3) @(negedge clock);
    end
`endif

    repeat (3) @(negedge clock);
    chk("sb_left", sb.size(), 0);
    chk("dq_left", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
